// File: rtl/spike_collector.sv
// spike_collector: sequencer and output stage for the neuron update engine.
// Issues either one engine init sweep or a T_STEPS-long presentation of
// per-neuron run pulses. It consumes the engine's valid/spike/index stream,
// accumulates a saturating spike count per neuron, emits a spike vector per
// timestep, and reports the argmax neuron at the end of the presentation.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           begin presentation (accepted in IDLE only)
//   i_init_req        begin engine init (accepted in IDLE only, wins over i_start)
//   i_cur_rdy         upstream currents for o_req_idx are valid
//   o_req_idx         neuron whose currents are requested
//   o_run, o_init     single-cycle pulses to the engine
//   i_s_init          engine init-in-progress flag
//   i_valid/i_spike/i_neuron_idx  engine neuron-done stream
//   o_step_valid      timestep complete, o_step_spikes valid this cycle
//   o_done            presentation complete, winner outputs valid
//   o_winner/o_winner_cnt/o_no_spike  classification result
//   o_busy            sequencer not idle
//   o_err             sticky protocol error
module spike_collector #(
  parameter int unsigned N_NEURON = 18,
  parameter int unsigned T_STEPS  = 350,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_init_req,
  input  logic                i_cur_rdy,
  output logic [4:0]          o_req_idx,
  output logic                o_run,
  output logic                o_init,
  input  logic                i_s_init,
  input  logic                i_valid,
  input  logic                i_spike,
  input  logic [4:0]          i_neuron_idx,
  output logic                o_step_valid,
  output logic [N_NEURON-1:0] o_step_spikes,
  output logic                o_done,
  output logic [4:0]          o_winner,
  output logic [CNT_W-1:0]    o_winner_cnt,
  output logic                o_no_spike,
  output logic                o_busy,
  output logic                o_err
);

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned STEP_W = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_NEURON - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_STEPS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE,
    INIT_PULSE,
    INIT_WAIT,
    ISSUE,
    WAIT,
    STEP,
    SCAN,
    DONE
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [STEP_W-1:0]   step_q;
  logic [CNT_W-1:0]    cnt_q [N_NEURON];
  logic [N_NEURON-1:0] step_vec_q;
  logic [CNT_W-1:0]    max_q;
  logic [IDX_W-1:0]    win_q;
  logic                init_seen_q;

  logic                run_q;
  logic                init_q;
  logic                step_valid_q;
  logic [N_NEURON-1:0] step_spikes_q;
  logic                done_q;
  logic [IDX_W-1:0]    winner_q;
  logic [CNT_W-1:0]    winner_cnt_q;
  logic                no_spike_q;
  logic                busy_q;
  logic                err_q;

  logic [CNT_W-1:0]    cnt_inc_d;
  logic [N_NEURON-1:0] step_vec_d;
  logic                scan_gt;
  logic [CNT_W-1:0]    max_d;
  logic [IDX_W-1:0]    win_d;

  // Saturating increment and spike-vector update for the neuron at idx_q.
  always_comb begin
    cnt_inc_d  = (cnt_q[idx_q] == CNT_MAX) ? CNT_MAX : cnt_q[idx_q] + CNT_W'(1);
    step_vec_d = step_vec_q;
    if (i_spike) begin
      step_vec_d = step_vec_q | (N_NEURON'(1) << idx_q);
    end
  end

  // Running argmax; strict greater-than keeps the lowest index on ties.
  always_comb begin
    scan_gt = (cnt_q[idx_q] > max_q);
    max_d   = scan_gt ? cnt_q[idx_q] : max_q;
    win_d   = scan_gt ? idx_q : win_q;
  end

  // Sequencer, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      step_q        <= '0;
      step_vec_q    <= '0;
      max_q         <= '0;
      win_q         <= '0;
      init_seen_q   <= 1'b0;
      run_q         <= 1'b0;
      init_q        <= 1'b0;
      step_valid_q  <= 1'b0;
      step_spikes_q <= '0;
      done_q        <= 1'b0;
      winner_q      <= '0;
      winner_cnt_q  <= '0;
      no_spike_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      for (int i = 0; i < int'(N_NEURON); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      run_q        <= 1'b0;
      init_q       <= 1'b0;
      step_valid_q <= 1'b0;
      done_q       <= 1'b0;

      case (state_q)
        IDLE: begin
          if (i_init_req) begin
            state_q     <= INIT_PULSE;
            init_q      <= 1'b1;
            init_seen_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
          end else if (i_start) begin
            state_q      <= ISSUE;
            busy_q       <= 1'b1;
            err_q        <= 1'b0;
            idx_q        <= '0;
            step_q       <= '0;
            step_vec_q   <= '0;
            winner_q     <= '0;
            winner_cnt_q <= '0;
            no_spike_q   <= 1'b0;
            for (int i = 0; i < int'(N_NEURON); i++) begin
              cnt_q[i] <= '0;
            end
          end
        end

        INIT_PULSE: begin
          state_q <= INIT_WAIT;
        end

        // Wait for the engine's init flag to rise and then fall.
        INIT_WAIT: begin
          if (i_s_init) begin
            init_seen_q <= 1'b1;
          end else if (init_seen_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        ISSUE: begin
          if (i_cur_rdy) begin
            run_q   <= 1'b1;
            state_q <= WAIT;
          end
        end

        // A mismatched engine index is flagged but the sample still lands at idx_q.
        WAIT: begin
          if (i_valid) begin
            if (i_neuron_idx != idx_q) begin
              err_q <= 1'b1;
            end
            if (i_spike) begin
              cnt_q[idx_q] <= cnt_inc_d;
            end
            step_vec_q <= step_vec_d;
            if (idx_q == LAST_IDX) begin
              idx_q         <= '0;
              state_q       <= STEP;
              step_valid_q  <= 1'b1;
              step_spikes_q <= step_vec_d;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= ISSUE;
            end
          end
        end

        STEP: begin
          step_vec_q    <= '0;
          step_spikes_q <= '0;
          if (step_q == LAST_STEP) begin
            state_q <= SCAN;
            idx_q   <= '0;
            max_q   <= '0;
            win_q   <= '0;
          end else begin
            step_q  <= step_q + STEP_W'(1);
            state_q <= ISSUE;
          end
        end

        // One counter per cycle; results are published on entry to DONE.
        SCAN: begin
          max_q <= max_d;
          win_q <= win_d;
          if (idx_q == LAST_IDX) begin
            idx_q        <= '0;
            state_q      <= DONE;
            done_q       <= 1'b1;
            winner_q     <= win_d;
            winner_cnt_q <= max_d;
            no_spike_q   <= (max_d == '0);
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // An engine strobe outside WAIT is a protocol error.
      if (i_valid && (state_q != WAIT)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign o_req_idx     = idx_q;
  assign o_run         = run_q;
  assign o_init        = init_q;
  assign o_step_valid  = step_valid_q;
  assign o_step_spikes = step_spikes_q;
  assign o_done        = done_q;
  assign o_winner      = winner_q;
  assign o_winner_cnt  = winner_cnt_q;
  assign o_no_spike    = no_spike_q;
  assign o_busy        = busy_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_spike_collector.sv
// Directed bench for spike_collector: instance A (T_STEPS=4, CNT_W=8) and
// instance S (T_STEPS=6, CNT_W=2) each driven by a small engine model that
// answers every o_run with i_valid 13 cycles later.
module tb_spike_collector;

  localparam int NN       = 18;
  localparam int TA       = 4;
  localparam int TS       = 6;
  localparam int LAT      = 13;
  localparam int PRES_A   = TA * (NN * 15 + 1) + NN + 1;
  localparam int PRES_S   = TS * (NN * 15 + 1) + NN + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A signals
  logic        a_start, a_init_req, a_cur_rdy, a_run, a_init, a_s_init;
  logic        a_valid, a_spike, a_step_valid, a_done, a_no_spike, a_busy, a_err;
  logic [4:0]  a_req_idx, a_nidx, a_winner;
  logic [17:0] a_step_spikes;
  logic [7:0]  a_winner_cnt;

  // Instance S signals
  logic        s_start, s_run, s_init, s_valid, s_spike, s_step_valid;
  logic        s_done, s_no_spike, s_busy, s_err;
  logic [4:0]  s_req_idx, s_nidx, s_winner;
  logic [17:0] s_step_spikes;
  logic [1:0]  s_winner_cnt;
  logic        s_init_req, s_cur_rdy, s_s_init;
  assign s_init_req = 1'b0;
  assign s_cur_rdy  = 1'b1;
  assign s_s_init   = 1'b0;

  spike_collector #(.N_NEURON(NN), .T_STEPS(TA), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_init_req(a_init_req),
    .i_cur_rdy(a_cur_rdy), .o_req_idx(a_req_idx), .o_run(a_run), .o_init(a_init),
    .i_s_init(a_s_init), .i_valid(a_valid), .i_spike(a_spike), .i_neuron_idx(a_nidx),
    .o_step_valid(a_step_valid), .o_step_spikes(a_step_spikes), .o_done(a_done),
    .o_winner(a_winner), .o_winner_cnt(a_winner_cnt), .o_no_spike(a_no_spike),
    .o_busy(a_busy), .o_err(a_err)
  );

  spike_collector #(.N_NEURON(NN), .T_STEPS(TS), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_init_req(s_init_req),
    .i_cur_rdy(s_cur_rdy), .o_req_idx(s_req_idx), .o_run(s_run), .o_init(s_init),
    .i_s_init(s_s_init), .i_valid(s_valid), .i_spike(s_spike), .i_neuron_idx(s_nidx),
    .o_step_valid(s_step_valid), .o_step_spikes(s_step_spikes), .o_done(s_done),
    .o_winner(s_winner), .o_winner_cnt(s_winner_cnt), .o_no_spike(s_no_spike),
    .o_busy(s_busy), .o_err(s_err)
  );

  // Controls written by the stimulus block only
  int   scenario;
  bit   stall_en, bad_en;
  logic spur_valid;

  // Engine model A state and monitors
  int          eng_cd = 0, lat_idx = 0, eng_step = 0;
  logic        eng_valid = 1'b0, eng_spike = 1'b0, rdy = 1'b1, s_init_r = 1'b0;
  logic [4:0]  eng_idx = '0;
  int          stall_cd = 0, stall_obs = 0, stall_viol = 0;
  int          init_cd = 0, init_cnt = 0, run_cnt = 0, overlap = 0, done_cnt = 0;
  int          s_fall_cyc = 0, busy_fall_cyc = 0, step_n = 0;
  logic        prev_busy = 1'b0;
  logic [17:0] step_log [128];

  assign a_valid   = eng_valid | spur_valid;
  assign a_spike   = eng_spike;
  assign a_nidx    = eng_idx;
  assign a_cur_rdy = rdy;
  assign a_s_init  = s_init_r;

  function automatic logic spike_of(input int sc, input int st, input int n);
    case (sc)
      0:       return (n == 5) || (n == 9 && (st == 0 || st == 2));
      1:       return (n == 3 || n == 12) && (st < 2);
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      eng_cd = 0; eng_valid = 1'b0; rdy = 1'b1; stall_cd = 0;
      init_cd = 0; s_init_r = 1'b0; eng_step = 0;
    end else begin
      eng_valid = 1'b0;
      if (!a_busy) eng_step = 0;
      if (stall_cd > 0) begin
        stall_cd--;
        if (stall_cd == 0) rdy = 1'b1;
        else begin
          stall_obs++;
          if (a_req_idx != 5'd4 || a_run) stall_viol++;
        end
      end
      if (init_cd > 0) begin
        init_cd--;
        if (init_cd == 0) begin s_init_r = 1'b0; s_fall_cyc = cyc; end
      end
      if (a_init) begin init_cnt++; s_init_r = 1'b1; init_cd = 18; end
      if (eng_cd > 0) begin
        eng_cd--;
        if (eng_cd == 0) begin
          eng_valid = 1'b1;
          if (bad_en && eng_step == 0 && lat_idx == 6) begin
            eng_idx   = 5'd7;
            eng_spike = 1'b1;
          end else begin
            eng_idx   = 5'(lat_idx);
            eng_spike = spike_of(scenario, eng_step, lat_idx);
          end
          if (stall_en && eng_step == 0 && lat_idx == 3) begin
            rdy = 1'b0; stall_cd = 8;
          end
        end
      end
      if (a_run) begin
        if (eng_cd > 0) overlap++;
        run_cnt++;
        eng_cd  = LAT;
        lat_idx = int'(a_req_idx);
      end
      if (a_step_valid) begin
        step_log[step_n % 128] = a_step_spikes;
        step_n++;
        eng_step++;
      end
      if (a_done) done_cnt++;
      if (prev_busy && !a_busy) busy_fall_cyc = cyc;
      prev_busy = a_busy;
    end
  end

  // Engine model S: neuron 0 spikes on every step
  int         s_cd = 0;
  logic [4:0] s_lat = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      s_cd = 0; s_valid = 1'b0; s_spike = 1'b0; s_nidx = '0;
    end else begin
      s_valid = 1'b0;
      if (s_cd > 0) begin
        s_cd--;
        if (s_cd == 0) begin
          s_valid = 1'b1; s_nidx = s_lat; s_spike = (s_lat == 5'd0);
        end
      end
      if (s_run) begin s_cd = LAT; s_lat = s_req_idx; end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_vecs(input string tag, input int sb,
                            input logic [17:0] v0, input logic [17:0] v1,
                            input logic [17:0] v2, input logic [17:0] v3);
    logic [17:0] ev [4];
    ev = '{v0, v1, v2, v3};
    check($sformatf("%s_nsteps", tag), 32'(step_n - sb), 32'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_vec%0d", tag, k), 32'(step_log[(sb + k) % 128]), 32'(ev[k]));
  endtask

  // Runs one presentation on instance A; returns start-to-done latency,
  // done pulses, run pulses and the step log index at start.
  task automatic present(input int sc, input bit stl, input bit bad, input bit mid,
                         output int lat, output int nd, output int runs, output int sb);
    int rb, db, t0, td;
    bit got;
    scenario = sc; stall_en = stl; bad_en = bad;
    @(negedge clk);
    rb = run_cnt; db = done_cnt; sb = step_n;
    a_start = 1'b1; t0 = cyc;
    @(negedge clk);
    a_start = 1'b0;
    got = 1'b0; td = t0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a_start = (mid && i == 500);
      if (a_done) begin got = 1'b1; td = cyc; break; end
    end
    check("done_seen", 32'(got), 32'd1);
    repeat (2) @(negedge clk);
    lat  = td - t0;
    nd   = done_cnt - db;
    runs = run_cnt - rb;
  endtask

  initial begin
    int lat, nd, runs, sb, ib, rb, so, sv, t0, td;
    bit got;
    a_start = 1'b0; a_init_req = 1'b0; s_start = 1'b0; spur_valid = 1'b0;
    scenario = 0; stall_en = 1'b0; bad_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_flags", 32'({a_run, a_init, a_step_valid, a_done, a_no_spike, a_busy, a_err}), 32'd0);
    check("rst_req_idx", 32'(a_req_idx), 32'd0);
    check("rst_winner", 32'({a_winner, a_winner_cnt}), 32'd0);
    check("rst_spikes", 32'(a_step_spikes), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Init, requested together with i_start: init wins
    ib = init_cnt; rb = run_cnt;
    a_init_req = 1'b1; a_start = 1'b1;
    @(negedge clk);
    a_init_req = 1'b0; a_start = 1'b0;
    check("init_pulse", 32'(a_init), 32'd1);
    check("init_busy", 32'(a_busy), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!a_busy) begin got = 1'b1; break; end
    end
    check("init_end", 32'(got), 32'd1);
    repeat (2) @(negedge clk);
    check("init_count", 32'(init_cnt - ib), 32'd1);
    check("init_no_run", 32'(run_cnt - rb), 32'd0);
    check("init_busy_fall", 32'(busy_fall_cyc - s_fall_cyc), 32'd1);

    // Main presentation
    present(0, 1'b0, 1'b0, 1'b0, lat, nd, runs, sb);
    check("p1_latency", 32'(lat), 32'(PRES_A));
    check("p1_done_cnt", 32'(nd), 32'd1);
    check("p1_runs", 32'(runs), 32'(TA * NN));
    check_vecs("p1", sb, 18'h00220, 18'h00020, 18'h00220, 18'h00020);
    check("p1_winner", 32'(a_winner), 32'd5);
    check("p1_winner_cnt", 32'(a_winner_cnt), 32'd4);
    check("p1_no_spike", 32'(a_no_spike), 32'd0);
    check("p1_err", 32'(a_err), 32'd0);
    check("p1_busy", 32'(a_busy), 32'd0);

    // Backpressure at neuron 4
    so = stall_obs; sv = stall_viol;
    present(0, 1'b1, 1'b0, 1'b0, lat, nd, runs, sb);
    check("bp_latency", 32'(lat), 32'(PRES_A + 7));
    check("bp_stall_cycles", 32'(stall_obs - so), 32'd7);
    check("bp_stall_viol", 32'(stall_viol - sv), 32'd0);
    check_vecs("bp", sb, 18'h00220, 18'h00020, 18'h00220, 18'h00020);
    check("bp_winner", 32'({a_winner, a_winner_cnt}), 32'({5'd5, 8'd4}));
    check("bp_err", 32'(a_err), 32'd0);

    // Engine returns index 7 while 6 is expected, with a spike
    present(0, 1'b0, 1'b1, 1'b0, lat, nd, runs, sb);
    check("idx_err", 32'(a_err), 32'd1);
    check_vecs("idx", sb, 18'h00260, 18'h00020, 18'h00220, 18'h00020);
    check("idx_winner", 32'({a_winner, a_winner_cnt}), 32'({5'd5, 8'd4}));

    // No spikes, with an i_start mid-run that must be ignored
    present(2, 1'b0, 1'b0, 1'b1, lat, nd, runs, sb);
    check("ns_latency", 32'(lat), 32'(PRES_A));
    check("ns_done_cnt", 32'(nd), 32'd1);
    check("ns_no_spike", 32'(a_no_spike), 32'd1);
    check("ns_winner", 32'({a_winner, a_winner_cnt}), 32'd0);
    check("ns_err_cleared", 32'(a_err), 32'd0);
    check("ns_overlap", 32'(overlap), 32'd0);

    // Spurious i_valid in IDLE
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    @(negedge clk);
    check("spur_err", 32'(a_err), 32'd1);
    check("spur_idle", 32'(a_busy), 32'd0);

    // Reset in the middle of WAIT for neuron 8
    scenario = 0; bad_en = 1'b1; stall_en = 1'b0;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (a_run && a_req_idx == 5'd8) begin got = 1'b1; break; end
    end
    check("mr_reach_wait", 32'(got), 32'd1);
    repeat (3) @(negedge clk);
    check("mr_err_before", 32'(a_err), 32'd1);
    check("mr_busy_before", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_flags", 32'({a_run, a_init, a_step_valid, a_done, a_no_spike, a_busy, a_err}), 32'd0);
    check("mr_req_idx", 32'(a_req_idx), 32'd0);
    check("mr_outs", 32'({a_winner, a_winner_cnt, a_step_spikes}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad_en = 1'b0;
    repeat (30) @(negedge clk);
    check("mr_quiet_after", 32'({a_busy, a_err}), 32'd0);

    // Tie between neurons 3 and 12
    present(1, 1'b0, 1'b0, 1'b0, lat, nd, runs, sb);
    check("tie_winner", 32'(a_winner), 32'd3);
    check("tie_winner_cnt", 32'(a_winner_cnt), 32'd2);
    check("tie_no_spike", 32'(a_no_spike), 32'd0);

    // Saturation on the CNT_W=2 instance
    @(negedge clk);
    s_start = 1'b1; t0 = cyc;
    @(negedge clk);
    s_start = 1'b0;
    got = 1'b0; td = t0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (s_done) begin got = 1'b1; td = cyc; break; end
    end
    check("sat_done_seen", 32'(got), 32'd1);
    check("sat_latency", 32'(td - t0), 32'(PRES_S));
    check("sat_winner", 32'(s_winner), 32'd0);
    check("sat_winner_cnt", 32'(s_winner_cnt), 32'd3);
    check("sat_flags", 32'({s_no_spike, s_err}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_collector.md
# spike_collector

Sequencer and output stage for the neuron update engine. Issues one init sweep or a T_STEPS-long presentation of per-neuron run pulses. Consumes the engine's spike/valid/index stream and accumulates a saturating spike count per neuron. At the end it emits a per-timestep spike vector for lateral inhibition/STDP and an argmax winner for classification.

## Interface
- N_NEURON, 18, neurons per sweep (indices 0..N_NEURON-1; engine wraps at 17)
- T_STEPS, 350, timesteps per sample presentation
- CNT_W, 8, spike counter width (saturating)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  pulse: begin presentation (accepted in IDLE only)
- i_init_req  in  1  pulse: run engine state init (accepted in IDLE only; i_init_req wins over i_start if both)
- i_cur_rdy  in  1  upstream currents for o_req_idx are valid
- o_req_idx  out  5  neuron whose currents are requested
- o_run  out  1  one-cycle pulse to engine i_run
- o_init  out  1  one-cycle pulse to engine i_init
- i_s_init  in  1  engine init-in-progress flag
- i_valid  in  1  engine neuron-done strobe
- i_spike  in  1  engine spike flag, sampled with i_valid
- i_neuron_idx  in  5  engine neuron index, sampled with i_valid
- o_step_valid  out  1  one-cycle pulse: timestep complete
- o_step_spikes  out  N_NEURON  spike vector of completed timestep
- o_done  out  1  one-cycle pulse: presentation complete
- o_winner  out  5  argmax neuron, held until next i_start
- o_winner_cnt  out  CNT_W  winner's spike count
- o_no_spike  out  1  no neuron spiked in the presentation
- o_busy  out  1  state != IDLE
- o_err  out  1  sticky protocol error, cleared on accepted i_start/i_init_req

## Operation
- States: IDLE, INIT_PULSE, INIT_WAIT, ISSUE, WAIT, STEP, SCAN, DONE.
- IDLE: i_init_req -> INIT_PULSE. Otherwise i_start -> ISSUE. On i_start: clear counters, step counter, neuron index, o_err and winner outputs.
- INIT_PULSE: o_init=1 for one cycle -> INIT_WAIT.
- INIT_WAIT: wait for i_s_init to rise, then fall -> IDLE.
- ISSUE: o_req_idx=idx. When i_cur_rdy=1, o_run=1 for that cycle -> WAIT.
- WAIT: on i_valid:
  - if i_neuron_idx != idx, set o_err; the sample is still used at position idx.
  - if i_spike, set step_vec[idx] and increment cnt[idx], saturating at 2^CNT_W-1.
  - if idx == N_NEURON-1: idx <- 0 -> STEP. Otherwise idx+1 -> ISSUE.
- STEP: o_step_valid=1, o_step_spikes=step_vec. step_vec cleared on the next cycle.
  - If step == T_STEPS-1 -> SCAN.
  - Otherwise step+1 -> ISSUE.
- SCAN: compare one counter per cycle, idx 0..N_NEURON-1 (N_NEURON cycles). Strict greater-than, so ties resolve to the lowest index -> DONE.
- DONE: o_done=1. Set o_winner/o_winner_cnt. o_no_spike = (max == 0), with winner 0 in that case -> IDLE.
- i_valid outside WAIT: ignored, sets o_err.
- i_start/i_init_req while busy: ignored, no error.
- No fixed-latency assumption on the engine. WAIT holds indefinitely.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, step_vec 0.
- o_run, o_init, o_step_valid, o_done: registered single-cycle pulses.
- o_step_spikes is stable only in the o_step_valid cycle.
- With the current engine and i_cur_rdy tied high:
  - o_run at cycle t -> i_valid at t+13.
  - Per neuron: 15 cycles (ISSUE 1 + WAIT 14).
  - Per step: 18*15+1 cycles.
  - Presentation: T_STEPS*(18*15+1) + N_NEURON + 1 cycles from i_start accept to o_done.
- Counter update, step_vec set and o_err set land the cycle after i_valid.
- Never more than one o_run outstanding.
- Reset mid-operation returns to IDLE immediately. The engine must be reset together with this block.

## Test plan
- Init: i_init_req, engine model holds i_s_init high 18 cycles -> exactly one o_init pulse, o_busy falls 1 cycle after i_s_init falls, no o_run.
- Presentation, T_STEPS=4: neuron 5 spikes every step, neuron 9 spikes in steps 0 and 2 -> 4 o_step_valid pulses (vectors 0x00220, 0x00020, 0x00220, 0x00020), o_done, o_winner=5, o_winner_cnt=4, o_no_spike=0, o_err=0.
- Tie and no-spike:
  - neurons 3 and 12 each spike 2 times -> o_winner=3.
  - no spikes -> o_no_spike=1, o_winner=0, o_winner_cnt=0.
- Saturation: CNT_W=2, T_STEPS=6, neuron 0 spikes every step -> o_winner_cnt=3.
- Backpressure: drop i_cur_rdy for 7 cycles at neuron 4 -> o_run delayed, o_req_idx stays 4, counts unchanged versus the no-stall run.
- Protocol errors:
  - i_neuron_idx=7 returned while 6 is expected -> o_err=1.
  - spurious i_valid in IDLE -> o_err=1.
  - i_start mid-run ignored.
  - rst_n asserted mid-WAIT -> all outputs 0 on the next cycle.
